// File: rtl/adder16_selftest.sv
// adder16_selftest: hardwired self-test sequencer around a 16-bit
// adder/subtractor. Five fixed operand pairs are run through the adder and
// each 16-bit result is streamed out MSB first as two strobed bytes.
// o_done goes high, and stays high, once the last byte has been written.
module adder16_selftest #(
  parameter int G_GAP = 1  // idle cycles after each LSB byte, 0..15
) (
  input  logic       i_clk,
  input  logic       i_rst,
  output logic [7:0] o_v_out,
  output logic       o_v_wr,
  output logic       o_done
);

  typedef enum logic [2:0] {
    ST_LOAD     = 3'd0,
    ST_CALC     = 3'd1,
    ST_EMIT_MSB = 3'd2,
    ST_EMIT_LSB = 3'd3,
    ST_GAP      = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'd4;
  localparam bit         GAP_EN   = (G_GAP != 0);
  // Terminal value of the gap counter; unused when the gap is disabled.
  localparam logic [3:0] GAP_LAST = (G_GAP > 0) ? 4'(G_GAP - 1) : 4'd0;

  // Vector table, packed as {A[15:0], op, B[15:0]}; op 0 = add, 1 = subtract.
  function automatic logic [32:0] vec_lookup(input logic [2:0] idx);
    logic [32:0] vec;
    case (idx)
      3'd0:    vec = {16'h1234, 1'b0, 16'h5678};
      3'd1:    vec = {16'hFFFF, 1'b0, 16'h0001};
      3'd2:    vec = {16'h8000, 1'b1, 16'h0001};
      3'd3:    vec = {16'h0000, 1'b1, 16'h0001};
      3'd4:    vec = {16'hABCD, 1'b0, 16'h0000};
      default: vec = 33'd0;
    endcase
    return vec;
  endfunction

  state_t      state_r,   state_nxt_s;
  logic [2:0]  idx_r,     idx_nxt_s;
  logic [3:0]  gap_cnt_r, gap_cnt_nxt_s;
  logic [15:0] a_r,       a_nxt_s;
  logic [15:0] b_r,       b_nxt_s;
  logic        op_r,      op_nxt_s;
  logic [15:0] res_r,     res_nxt_s;
  logic [7:0]  v_out_r,   v_out_nxt_s;
  logic        v_wr_r,    v_wr_nxt_s;
  logic        done_r,    done_nxt_s;

  logic [32:0] vec_s;
  logic [15:0] sum_s;
  // Carry/borrow out of the adder; kept internal, results wrap silently.
  logic        calc_carry_unused_s;
  state_t      adv_state_s;
  logic [2:0]  adv_idx_s;

  assign vec_s = vec_lookup(idx_r);

  // 17-bit add/subtract so the carry/borrow is formed alongside the result.
  assign {calc_carry_unused_s, sum_s} = op_r ? ({1'b0, a_r} - {1'b0, b_r})
                                             : ({1'b0, a_r} + {1'b0, b_r});

  // Where to go once a result has been fully emitted: next vector or finish.
  always_comb begin
    adv_state_s = ST_LOAD;
    adv_idx_s   = idx_r;
    if (idx_r == LAST_IDX) begin
      adv_state_s = ST_DONE;
      adv_idx_s   = idx_r;
    end else begin
      adv_state_s = ST_LOAD;
      adv_idx_s   = idx_r + 3'd1;
    end
  end

  // Next-state and next-output logic; outputs are precomputed for registering.
  always_comb begin
    state_nxt_s   = state_r;
    idx_nxt_s     = idx_r;
    gap_cnt_nxt_s = gap_cnt_r;
    a_nxt_s       = a_r;
    b_nxt_s       = b_r;
    op_nxt_s      = op_r;
    res_nxt_s     = res_r;
    v_out_nxt_s   = v_out_r;
    v_wr_nxt_s    = 1'b0;
    done_nxt_s    = done_r;
    case (state_r)
      ST_LOAD: begin
        a_nxt_s     = vec_s[32:17];
        op_nxt_s    = vec_s[16];
        b_nxt_s     = vec_s[15:0];
        state_nxt_s = ST_CALC;
      end
      ST_CALC: begin
        res_nxt_s   = sum_s;
        state_nxt_s = ST_EMIT_MSB;
      end
      ST_EMIT_MSB: begin
        v_out_nxt_s = res_r[15:8];
        v_wr_nxt_s  = 1'b1;
        state_nxt_s = ST_EMIT_LSB;
      end
      ST_EMIT_LSB: begin
        v_out_nxt_s   = res_r[7:0];
        v_wr_nxt_s    = 1'b1;
        gap_cnt_nxt_s = 4'd0;
        if (GAP_EN) begin
          state_nxt_s = ST_GAP;
        end else begin
          state_nxt_s = adv_state_s;
          idx_nxt_s   = adv_idx_s;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_nxt_s = adv_state_s;
          idx_nxt_s   = adv_idx_s;
        end else begin
          gap_cnt_nxt_s = gap_cnt_r + 4'd1;
        end
      end
      ST_DONE: begin
        done_nxt_s  = 1'b1;
        state_nxt_s = ST_DONE;
      end
      default: begin
        state_nxt_s = ST_LOAD;
      end
    endcase
  end

  // State, datapath and output registers; reset restarts from vector 0.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r   <= ST_LOAD;
      idx_r     <= 3'd0;
      gap_cnt_r <= 4'd0;
      a_r       <= 16'h0000;
      b_r       <= 16'h0000;
      op_r      <= 1'b0;
      res_r     <= 16'h0000;
      v_out_r   <= 8'h00;
      v_wr_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      idx_r     <= idx_nxt_s;
      gap_cnt_r <= gap_cnt_nxt_s;
      a_r       <= a_nxt_s;
      b_r       <= b_nxt_s;
      op_r      <= op_nxt_s;
      res_r     <= res_nxt_s;
      v_out_r   <= v_out_nxt_s;
      v_wr_r    <= v_wr_nxt_s;
      done_r    <= done_nxt_s;
    end
  end

  assign o_v_out = v_out_r;
  assign o_v_wr  = v_wr_r;
  assign o_done  = done_r;

endmodule

// File: tb/tb_adder16_selftest.sv
// Directed bench for adder16_selftest: three instances (G_GAP = 1, 0, 3)
// share one clock and have independent resets. Expected byte stream and
// strobe/done timing come from the hand-computed vector table below.
module tb_adder16_selftest;

  logic       clk = 1'b0;
  logic [2:0] rst_v;
  logic [7:0] out_v [3];
  logic [2:0] wr_v;
  logic [2:0] done_v;

  int total = 0;
  int bad   = 0;

  // Hand-computed results, MSB then LSB, for vectors 0..4.
  logic [7:0] exp_b [10] = '{8'h68, 8'hAC, 8'h00, 8'h00, 8'h7F,
                             8'hFF, 8'hFF, 8'hFF, 8'hAB, 8'hCD};

  always #5 clk = ~clk;

  adder16_selftest #(.G_GAP(1)) u_dut_g1 (
    .i_clk(clk), .i_rst(rst_v[0]), .o_v_out(out_v[0]), .o_v_wr(wr_v[0]), .o_done(done_v[0])
  );
  adder16_selftest #(.G_GAP(0)) u_dut_g0 (
    .i_clk(clk), .i_rst(rst_v[1]), .o_v_out(out_v[1]), .o_v_wr(wr_v[1]), .o_done(done_v[1])
  );
  adder16_selftest #(.G_GAP(3)) u_dut_g3 (
    .i_clk(clk), .i_rst(rst_v[2]), .o_v_out(out_v[2]), .o_v_wr(wr_v[2]), .o_done(done_v[2])
  );

  // All instances held in reset for 5 cycles: every output must stay cleared.
  task automatic test_reset();
    rst_v = 3'b000;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        total++;
        if (wr_v[k] !== 1'b0) begin
          bad++;
          $display("FAIL reset_wr dut%0d cycle %0d: got %b want 0", k, c, wr_v[k]);
        end
        total++;
        if (out_v[k] !== 8'h00) begin
          bad++;
          $display("FAIL reset_out dut%0d cycle %0d: got %h want 00", k, c, out_v[k]);
        end
        total++;
        if (done_v[k] !== 1'b0) begin
          bad++;
          $display("FAIL reset_done dut%0d cycle %0d: got %b want 0", k, c, done_v[k]);
        end
      end
    end
  endtask

  // Release reset on instance k and check every cycle of the full run plus
  // 20 cycles after done: strobe timing, byte values, hold, done timing.
  task automatic test_stream(input int k, input int gap);
    int         p;
    int         last;
    int         idx;
    int         rel;
    int         nstrobe;
    logic       exp_wr;
    logic       exp_done;
    logic [7:0] exp_out;
    p       = 4 + gap;
    last    = 5 * p + 20;
    nstrobe = 0;
    exp_out = 8'h00;
    rst_v[k] = 1'b0;
    @(negedge clk);
    rst_v[k] = 1'b1;
    for (int e = 0; e <= last; e++) begin
      @(posedge clk);
      #1;
      idx      = e / p;
      rel      = e % p;
      exp_wr   = (idx < 5) && (rel == 2 || rel == 3);
      exp_done = (e >= 5 * p);
      if (exp_wr) begin
        exp_out = exp_b[idx * 2 + rel - 2];
      end
      if (wr_v[k] === 1'b1) begin
        nstrobe++;
      end
      total++;
      if (wr_v[k] !== exp_wr) begin
        bad++;
        $display("FAIL stream_wr gap%0d edge %0d: got %b want %b", gap, e, wr_v[k], exp_wr);
      end
      total++;
      if (out_v[k] !== exp_out) begin
        bad++;
        $display("FAIL stream_out gap%0d edge %0d: got %h want %h", gap, e, out_v[k], exp_out);
      end
      total++;
      if (done_v[k] !== exp_done) begin
        bad++;
        $display("FAIL stream_done gap%0d edge %0d: got %b want %b", gap, e, done_v[k], exp_done);
      end
      total++;
      if (wr_v[k] === 1'b1 && done_v[k] === 1'b1) begin
        bad++;
        $display("FAIL stream_wr_done_overlap gap%0d edge %0d: got wr=1 done=1 want not both", gap, e);
      end
    end
    total++;
    if (nstrobe !== 10) begin
      bad++;
      $display("FAIL stream_count gap%0d: got %0d strobes want 10", gap, nstrobe);
    end
  endtask

  // Mid-sequence asynchronous reset on the default instance, then full restart.
  task automatic test_async_reset();
    rst_v[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_v[0] = 1'b1;
    for (int e = 0; e <= 12; e++) begin
      @(posedge clk);
      #1;
    end
    // Edge 12 carries vector 2's MSB strobe (7F), after the 4th byte.
    total++;
    if (wr_v[0] !== 1'b1 || out_v[0] !== 8'h7F) begin
      bad++;
      $display("FAIL async_pre: got wr=%b out=%h want wr=1 out=7f", wr_v[0], out_v[0]);
    end
    #3;
    rst_v[0] = 1'b0;
    #1;
    total++;
    if (wr_v[0] !== 1'b0 || out_v[0] !== 8'h00 || done_v[0] !== 1'b0) begin
      bad++;
      $display("FAIL async_clear: got wr=%b out=%h done=%b want 0 00 0",
               wr_v[0], out_v[0], done_v[0]);
    end
    @(posedge clk);
    #1;
    total++;
    if (wr_v[0] !== 1'b0 || out_v[0] !== 8'h00 || done_v[0] !== 1'b0) begin
      bad++;
      $display("FAIL async_held: got wr=%b out=%h done=%b want 0 00 0",
               wr_v[0], out_v[0], done_v[0]);
    end
    test_stream(0, 1);
  endtask

  // Scenario sequence and summary.
  initial begin
    rst_v = 3'b000;
    test_reset();
    test_stream(0, 1);
    test_async_reset();
    test_stream(1, 0);
    test_stream(2, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
